// File: rtl/d_latch_pkg.sv
// Shared defaults for the latch-free gated D latch cell.
package d_latch_pkg;

  localparam int DEFAULT_WIDTH = 1;

  // Fill bit for the default reset value; replicated to WIDTH by the cell.
  localparam logic RESET_FILL = 1'b0;

endpackage

// File: rtl/d_latch.sv
// Gated D latch built from a clocked holding register plus a combinational
// bypass, so it is transparent with zero latency yet infers no latch.
module d_latch
  import d_latch_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{RESET_FILL}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             e,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_d;

  always_comb begin
    hold_d = hold_q;
    if (e) begin
      hold_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= RESET_VAL;
    end else begin
      hold_q <= hold_d;
    end
  end

  // rst must override the bypass too, otherwise e=1 would leak d during reset.
  always_comb begin
    q = hold_q;
    if (rst) begin
      q = RESET_VAL;
    end else if (e) begin
      q = d;
    end
  end

  assign q_bar = ~q;

`ifdef SIMULATION
  always_comb begin
    assert (q_bar == ~q);
  end
`endif

endmodule

// File: tb/tb_d_latch.sv
// Directed bench for d_latch: one 1-bit and one 8-bit (RESET_VAL=A5) instance.
module tb_d_latch;

  logic       clk;
  logic       rst;
  logic       e1;
  logic [0:0] d1;
  logic [0:0] q1;
  logic [0:0] qb1;
  logic       e8;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] qb8;

  logic [7:0] exp_q[$];
  int         n_cmp;
  int         n_mism;

  d_latch #(.WIDTH(1)) u_w1 (
    .clk   (clk),
    .rst   (rst),
    .d     (d1),
    .e     (e1),
    .q     (q1),
    .q_bar (qb1)
  );

  d_latch #(.WIDTH(8), .RESET_VAL(8'hA5)) u_w8 (
    .clk   (clk),
    .rst   (rst),
    .d     (d8),
    .e     (e8),
    .q     (q8),
    .q_bar (qb8)
  );

  // Clock: rising edges at 5, 15, 25, ... ; inputs change on falling edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp_v;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mism++;
      $error("FAIL %s: observed=%h expected=<empty queue>", tag, obs);
      return;
    end
    exp_v = exp_q.pop_front();
    assert (obs === exp_v) else begin
      n_mism++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic exp1(input logic qv);
    exp_q.push_back({7'b0, qv});
    exp_q.push_back({7'b0, ~qv});
  endtask

  task automatic chk1(input string tag);
    check({tag, ".q"}, {7'b0, q1});
    check({tag, ".q_bar"}, {7'b0, qb1});
  endtask

  task automatic exp8(input logic [7:0] qv);
    exp_q.push_back(qv);
    exp_q.push_back(~qv);
  endtask

  task automatic chk8(input string tag);
    check({tag, ".q8"}, q8);
    check({tag, ".q_bar8"}, qb8);
  endtask

  task automatic drive1(input logic ev, input logic dv);
    e1 = ev;
    d1 = dv;
  endtask

  logic [1:0] sweep_ed[4];
  logic       sweep_q[4];

  initial begin
    n_cmp  = 0;
    n_mism = 0;
    sweep_ed = '{2'b00, 2'b01, 2'b10, 2'b11};
    sweep_q  = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Reset asserted while transparent: RESET_VAL wins over d.
    rst = 1'b1;
    drive1(1'b1, 1'b1);
    e8 = 1'b1;
    d8 = 8'hFF;
    exp1(1'b0);
    exp8(8'hA5);
    #1;
    chk1("rst_transparent");
    chk8("rst_transparent");

    // Release with e=0: outputs stay at RESET_VAL across clock edges.
    @(negedge clk);
    drive1(1'b0, 1'b1);
    e8  = 1'b0;
    rst = 1'b0;
    exp1(1'b0);
    exp8(8'hA5);
    #1;
    chk1("release_e0");
    chk8("release_e0");
    repeat (2) @(negedge clk);
    exp1(1'b0);
    #1;
    chk1("release_e0_held");

    // Enable sweep {e,d} = 00, 01, 10, 11, each across one rising edge.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive1(sweep_ed[i][1], sweep_ed[i][0]);
      exp1(sweep_q[i]);
      #1;
      chk1($sformatf("sweep%0d_pre", i));
      @(negedge clk);
      exp1(sweep_q[i]);
      #1;
      chk1($sformatf("sweep%0d_post", i));
    end

    // Hold: capture 1 over two edges, then toggle d with e=0.
    @(negedge clk);
    drive1(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    drive1(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      d1 = (i % 2 == 0) ? 1'b0 : 1'b1;
      exp1(1'b1);
      #1;
      chk1($sformatf("hold%0d", i));
      @(negedge clk);
    end

    // Transparency: mid-cycle d change shows up without a clock edge.
    drive1(1'b1, 1'b0);
    exp1(1'b0);
    #1;
    chk1("transp_d0");
    #1;
    d1 = 1'b1;
    exp1(1'b1);
    #0.1;
    chk1("transp_d1_same_step");

    // Async reset between edges while transparent.
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp1(1'b0);
    exp8(8'hA5);
    #1;
    chk1("midrst_asserted");
    chk8("midrst_asserted");
    rst = 1'b0;
    exp1(1'b1);
    #0.1;
    chk1("midrst_released");
    @(negedge clk);
    e1 = 1'b0;
    exp1(1'b1);
    #1;
    chk1("midrst_then_hold");

    // 8-bit capture of 3C after reset, then hold against d changes.
    @(negedge clk);
    e8 = 1'b1;
    d8 = 8'h3C;
    exp8(8'h3C);
    #1;
    chk8("w8_transparent");
    @(negedge clk);
    e8 = 1'b0;
    exp8(8'h3C);
    #1;
    chk8("w8_hold");
    d8 = 8'h00;
    @(negedge clk);
    exp8(8'h3C);
    #1;
    chk8("w8_hold_dchange");

    if (exp_q.size() != 0) begin
      n_mism++;
      $display("FAIL scoreboard_leftover: observed=%0d entries expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule
